median_frame_writer: RTL
========================

Name: median_frame_writer

Overview:
- Back end of the median filter datapath; the opposite end of the line-buffer pixel stream.
- Accepts the filtered pixel stream over a valid/ready handshake and discards the line-buffer warm-up samples.
- Assigns a raster address to each kept pixel, optionally forces border pixels to zero, and writes exactly one frame to image memory through a registered, back-pressured write port.
- Signals frame completion.

Parameters:
- IMG_Width, 256, pixels per row (>=3)
- IMG_Height, 256, rows per frame (>=3)
- Datawidth, 8, pixel width in bits
- AddrWidth, 16, memory address width; must satisfy 2^AddrWidth >= IMG_Width*IMG_Height
- WARMUP, 257, accepted input samples discarded before the first kept pixel (default IMG_Width+1)
- BORDER_ZERO, 1, 1 = pixels in row 0, row IMG_Height-1, col 0 or col IMG_Width-1 are written as 0; 0 = written unmodified

Ports:
- CLK  input  1  clock, rising edge
- CLR  input  1  synchronous active-high reset
- START  input  1  one-cycle request to begin a frame; honoured only in IDLE
- IN_VALID  input  1  filtered pixel present on In
- In  input  Datawidth  filtered pixel
- IN_READY  output  1  block accepts In this cycle
- MEM_WE  output  1  write request valid
- MEM_ADDR  output  AddrWidth  write address, row*IMG_Width+col
- MEM_DATA  output  Datawidth  write data
- MEM_READY  input  1  memory accepts the write this cycle
- BUSY  output  1  high from START acceptance until FRAME_DONE
- FRAME_DONE  output  1  one-cycle pulse after the final write is accepted

Behaviour:
- Reset (CLR=1 at a rising edge; any state, including mid-frame):
  - state=IDLE; all counters 0.
  - MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, BUSY=0, FRAME_DONE=0, IN_READY=0.
  - A pending unaccepted write is dropped.
- Input acceptance: a sample is accepted when IN_VALID && IN_READY. In WRITE, IN_READY = !MEM_WE || MEM_READY (single output register, no bubble under continuous flow).
- Write acceptance: a write completes when MEM_WE && MEM_READY. MEM_WE, MEM_ADDR and MEM_DATA are held stable while MEM_WE=1 && MEM_READY=0.
- States:
  - IDLE: IN_READY=0. START -> SKIP if WARMUP>0, else -> WRITE. BUSY rises the next cycle.
  - SKIP: IN_READY=1. Accepted samples are counted and discarded. The WARMUP-th accepted sample -> WRITE.
  - WRITE: each accepted sample loads the output register one cycle later: MEM_WE=1, MEM_ADDR=current row*IMG_Width+col, MEM_DATA=In, or 0 if BORDER_ZERO and the pixel is on the border.
    - col increments per accepted sample; at IMG_Width-1 it wraps to 0 and row increments.
    - After the IMG_Width*IMG_Height-th sample is accepted, IN_READY=0 and the state -> FLUSH.
  - FLUSH: wait for the final write acceptance -> DONE.
  - DONE: FRAME_DONE=1 for exactly one cycle, BUSY=0 in the same cycle -> IDLE.
- Latency: accepted sample to MEM_WE assertion is 1 cycle.
- Address arithmetic: row and col are separate counters; the address is computed with AddrWidth-bit arithmetic and never wraps within a frame.
- START outside IDLE is ignored. START and CLR in the same cycle: CLR wins.
- Samples presented with IN_READY=0 are not consumed.
- Border test uses the row/col of the pixel being written, not the input index.
- Exactly IMG_Width*IMG_Height writes per frame; no write is issued for warm-up samples.

Test Plan:
- IMG_Width=4, IMG_Height=3, WARMUP=5, BORDER_ZERO=0; START, then 17 samples In=1..17, IN_VALID=1 continuously, MEM_READY=1 -> 12 writes, addr 0..11, data 6..17 on consecutive cycles; FRAME_DONE pulses once, one cycle after write addr 11.
- Same config with BORDER_ZERO=1 -> writes at addr 5 and 6 carry data 11 and 12; all other addresses carry 0.
- Back-pressure: MEM_READY toggled 1,0,0,1 repeatedly -> MEM_ADDR/MEM_DATA are held while stalled; IN_READY=0 during stalls; the sequence is identical to the first test with no loss or duplication.
- IN_VALID gaps (valid every 3rd cycle) -> same 12 writes in order; FRAME_DONE only after the 17th sample.
- CLR asserted after the 3rd write, then START and a full 17-sample stream -> all outputs at reset values the cycle after CLR; the new frame restarts at addr 0 with data 6.
- START pulsed during WRITE -> ignored; BUSY stays 1; exactly 12 writes and one FRAME_DONE.

Source files
------------

// File: rtl/median_frame_writer.sv
// ============================================================================
// median_frame_writer
// Back end of the median filter: drops line-buffer warm-up samples and writes
// exactly one raster frame into image memory through a back-pressured port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module median_frame_writer #(
    parameter int IMG_Width   = 256,
    parameter int IMG_Height  = 256,
    parameter int Datawidth   = 8,
    parameter int AddrWidth   = 16,
    parameter int WARMUP      = 257,
    parameter int BORDER_ZERO = 1
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 START,
    input  logic                 IN_VALID,
    input  logic [Datawidth-1:0] In,
    output logic                 IN_READY,
    output logic                 MEM_WE,
    output logic [AddrWidth-1:0] MEM_ADDR,
    output logic [Datawidth-1:0] MEM_DATA,
    input  logic                 MEM_READY,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int CW = (IMG_Width  > 1) ? $clog2(IMG_Width)  : 1;
    localparam int RW = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;
    localparam int SW = (WARMUP     > 1) ? $clog2(WARMUP)     : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKIP  = 3'd1,
        S_WRITE = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SW-1:0]          skip_q;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic                   we_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [Datawidth-1:0]   data_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   in_ready_d;
    logic                   accept_d;
    logic                   col_last_d;
    logic                   row_last_d;
    logic                   border_d;
    logic [AddrWidth-1:0]   addr_d;
    logic [Datawidth-1:0]   data_d;

    // In WRITE the single output register may refill in the same cycle it retires.
    always_comb begin
        in_ready_d = 1'b0;
        case (state_q)
            S_SKIP:  in_ready_d = 1'b1;
            S_WRITE: in_ready_d = !we_q || MEM_READY;
            default: in_ready_d = 1'b0;
        endcase
    end

    assign accept_d   = IN_VALID && in_ready_d;
    assign col_last_d = (col_q == CW'(IMG_Width - 1));
    assign row_last_d = (row_q == RW'(IMG_Height - 1));
    assign border_d   = (row_q == '0) || row_last_d || (col_q == '0) || col_last_d;
    assign addr_d     = AddrWidth'(row_q) * AddrWidth'(IMG_Width) + AddrWidth'(col_q);
    assign data_d     = ((BORDER_ZERO != 0) && border_d) ? '0 : In;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (we_q && MEM_READY) begin
                we_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        busy_q  <= 1'b1;
                        state_q <= (WARMUP > 0) ? S_SKIP : S_WRITE;
                    end
                end
                S_SKIP: begin
                    if (accept_d) begin
                        if (skip_q == SW'(WARMUP - 1)) begin
                            skip_q  <= '0;
                            state_q <= S_WRITE;
                        end else begin
                            skip_q <= skip_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (accept_d) begin
                        we_q   <= 1'b1;
                        addr_q <= addr_d;
                        data_q <= data_d;
                        if (col_last_d) begin
                            col_q <= '0;
                            if (row_last_d) begin
                                row_q   <= '0;
                                state_q <= S_FLUSH;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // The last pixel still sits in the output register.
                    if (!we_q || MEM_READY) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY   = in_ready_d;
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_DATA   = data_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;

endmodule

`default_nettype wire
